// File: rtl/bsg_manycore_io_host_bridge.sv
// bsg_manycore_io_host_bridge
// Host-side endpoint on one column's IO link. It turns host store/load
// requests into forward packets, tracks outstanding-request credits and
// hands load return data back through a first-word fall-through FIFO.
//
// Optional feature: define BSG_MANYCORE_IO_BRIDGE_FENCE_EN to add fence_i
// and fence_done_o. While fence_i is high, new requests are held off until
// every credit is home and the send register is empty.
//
// link_sif layout, MSB..LSB, identical in both directions:
//   {fwd_v, fwd_data[fwd_pkt], fwd_ready_and, rev_v, rev_data[ret_pkt], rev_ready_and}
// fwd packet, MSB..LSB: {addr, we, mask, payload, src_y, src_x, dst_y, dst_x}
// ret packet, MSB..LSB: {is_load, data}
module bsg_manycore_io_host_bridge
  #(parameter addr_width_p      = 28
   ,parameter data_width_p      = 32
   ,parameter x_cord_width_p    = 4
   ,parameter y_cord_width_p    = 4
   ,parameter max_out_credits_p = 16
   ,parameter resp_fifo_els_p   = 4
   ,localparam mask_width_lp     = data_width_p/8
   ,localparam fwd_pkt_width_lp  = addr_width_p + 1 + mask_width_lp + data_width_p
                                   + 2*(x_cord_width_p + y_cord_width_p)
   ,localparam ret_pkt_width_lp  = 1 + data_width_p
   ,localparam link_sif_width_lp = 4 + fwd_pkt_width_lp + ret_pkt_width_lp
   ,localparam credit_width_lp   = $clog2(max_out_credits_p+1))
  (input  logic                         clk_i
  ,input  logic                         reset_i
  ,input  logic [x_cord_width_p-1:0]    my_x_i
  ,input  logic [y_cord_width_p-1:0]    my_y_i
  ,input  logic                         host_v_i
  ,input  logic                         host_we_i
  ,input  logic [addr_width_p-1:0]      host_addr_i
  ,input  logic [data_width_p-1:0]      host_data_i
  ,input  logic [mask_width_lp-1:0]     host_mask_i
  ,input  logic [x_cord_width_p-1:0]    host_x_i
  ,input  logic [y_cord_width_p-1:0]    host_y_i
  ,output logic                         host_ready_o
  ,output logic                         resp_v_o
  ,output logic [data_width_p-1:0]      resp_data_o
  ,input  logic                         resp_yumi_i
  ,input  logic [link_sif_width_lp-1:0] link_sif_i
  ,output logic [link_sif_width_lp-1:0] link_sif_o
  ,output logic [credit_width_lp-1:0]   out_credits_o
`ifdef BSG_MANYCORE_IO_BRIDGE_FENCE_EN
  ,input  logic                         fence_i
  ,output logic                         fence_done_o
`endif
  ,output logic                         idle_o
  );

   localparam ptr_width_lp = $clog2(resp_fifo_els_p);
   localparam cnt_width_lp = $clog2(resp_fifo_els_p+1);
   localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

   typedef enum logic {EMPTY, FULL} state_e;
   state_e state_r, state_n;

   // link unpacking
   logic                        fwd_v_in, fwd_ready_in, rev_v_in, rev_ready_in;
   logic [fwd_pkt_width_lp-1:0] fwd_data_in;
   logic [ret_pkt_width_lp-1:0] rev_data_in;
   assign fwd_v_in     = link_sif_i[link_sif_width_lp-1];
   assign fwd_data_in  = link_sif_i[link_sif_width_lp-2 -: fwd_pkt_width_lp];
   assign fwd_ready_in = link_sif_i[ret_pkt_width_lp+2];
   assign rev_v_in     = link_sif_i[ret_pkt_width_lp+1];
   assign rev_data_in  = link_sif_i[ret_pkt_width_lp:1];
   assign rev_ready_in = link_sif_i[0];

   // inbound forward traffic is not supported, so its payload is ignored
   logic unused_link_bits;
   assign unused_link_bits = ^{fwd_data_in, rev_ready_in};

   logic [fwd_pkt_width_lp-1:0] pkt_r, pkt_n;
   logic [credit_width_lp-1:0]  credits_r, credits_n;
   logic                        fwd_v_o, rev_ready_o, send_hs, ret_hs, load_pkt;

   // response FIFO state
   logic [data_width_p-1:0] mem_r [resp_fifo_els_p];
   logic [ptr_width_lp-1:0] wptr_r, rptr_r;
   logic [cnt_width_lp-1:0] cnt_r;
   logic                    fifo_full, fifo_empty, push, pop;

   assign fifo_full  = (cnt_r == cnt_width_lp'(resp_fifo_els_p));
   assign fifo_empty = (cnt_r == '0);

   assign fwd_v_o     = (state_r == FULL) & ~reset_i;
   assign rev_ready_o = ~fifo_full & ~reset_i;
   assign send_hs     = fwd_v_o & fwd_ready_in;
   assign ret_hs      = rev_v_in & rev_ready_o;
   assign push        = ret_hs & rev_data_in[ret_pkt_width_lp-1];
   assign pop         = resp_yumi_i & ~fifo_empty;

   // a send and a return in the same cycle cancel out
   always_comb begin
      credits_n = credits_r;
      if (send_hs & ~ret_hs)
         credits_n = credits_r - 1'b1;
      else if (ret_hs & ~send_hs)
         credits_n = credits_r + 1'b1;
   end

   // host_ready looks at state and credits (plus the network handshake
   // that frees the send register), never at host_v_i
   logic ready_fsm;
   always_comb begin
      ready_fsm = 1'b0;
      if (state_r == EMPTY)
         ready_fsm = (credits_r != '0);
      else
         ready_fsm = send_hs & (credits_n != '0);
   end

`ifdef BSG_MANYCORE_IO_BRIDGE_FENCE_EN
   assign host_ready_o = ready_fsm & ~reset_i
                       & (~fence_i | ((credits_r == max_credits_lp) & (state_r == EMPTY)));
   assign fence_done_o = fence_i & idle_o;
`else
   assign host_ready_o = ready_fsm & ~reset_i;
`endif

   assign load_pkt = host_v_i & host_ready_o;

   // next state and formatted packet; loads carry zero payload
   always_comb begin
      state_n = state_r;
      pkt_n   = {host_addr_i, host_we_i, host_mask_i,
                 (host_we_i ? host_data_i : {data_width_p{1'b0}}),
                 my_y_i, my_x_i, host_y_i, host_x_i};
      case (state_r)
         EMPTY: if (load_pkt) state_n = FULL;
         FULL:  if (send_hs)  state_n = load_pkt ? FULL : EMPTY;
         default: state_n = EMPTY;
      endcase
   end

   // FSM state, send register and credit counter
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r   <= EMPTY;
         credits_r <= max_credits_lp;
         pkt_r     <= '0;
      end else begin
         state_r   <= state_n;
         credits_r <= credits_n;
         if (load_pkt) pkt_r <= pkt_n;
      end
   end

   // response FIFO pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_r <= '0;
         rptr_r <= '0;
         cnt_r  <= '0;
      end else begin
         if (push)
            wptr_r <= (wptr_r == ptr_width_lp'(resp_fifo_els_p-1)) ? '0 : wptr_r + 1'b1;
         if (pop)
            rptr_r <= (rptr_r == ptr_width_lp'(resp_fifo_els_p-1)) ? '0 : rptr_r + 1'b1;
         if (push & ~pop)
            cnt_r <= cnt_r + 1'b1;
         else if (pop & ~push)
            cnt_r <= cnt_r - 1'b1;
      end
   end

   // response FIFO storage, no reset needed
   always_ff @(posedge clk_i) begin
      if (push) mem_r[wptr_r] <= rev_data_in[data_width_p-1:0];
   end

   assign resp_v_o      = ~fifo_empty & ~reset_i;
   assign resp_data_o   = mem_r[rptr_r];
   assign out_credits_o = credits_r;
   assign idle_o        = (credits_r == max_credits_lp) & (state_r == EMPTY) & fifo_empty;

   // outbound: our fwd packet, no inbound-fwd ready, no rev traffic
   assign link_sif_o = {fwd_v_o, pkt_r, 1'b0, 1'b0, {ret_pkt_width_lp{1'b0}}, rev_ready_o};

`ifndef SYNTHESIS
   // protocol checks for illegal network behaviour
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(ret_hs && credits_r == max_credits_lp))
            else $error("credit return with no request outstanding");
         assert (!fwd_v_in)
            else $error("inbound forward packet not supported");
      end
   end
`endif

endmodule
